// File: rtl/delqa_pkg.sv
// delqa_pkg: shared types and constants for the DELQA buffer-descriptor datapath.
package delqa_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_HRD,
    S_BWR,
    S_FWR,
    S_SRD,
    S_SWT,
    S_SWR,
    S_DONE
  } state_e;
  localparam logic [2:0] BDL_FLAG    = 3'd0;
  localparam logic [2:0] BDL_ADDR_HI = 3'd1;
  localparam logic [2:0] BDL_ADDR_LO = 3'd2;
  localparam logic [2:0] BDL_LEN     = 3'd3;
  localparam logic [2:0] BDL_ST1     = 3'd4;
  localparam logic [2:0] BDL_ST2     = 3'd5;
  localparam int BIT_V = 15;
  localparam int BIT_C = 14;
  localparam logic [15:0] FLAG_USE = 16'hC000;
endpackage

// File: rtl/bdlf_qm_req.sv
// bdlf_qm_req: holds one host request until ack/err; optional timeout when BDLF_TIMEOUT_EN is defined.
module bdlf_qm_req #(
  parameter int AW         = 21,
  parameter int TMO_CYCLES = 1023
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          req_i,
  input  logic [AW-1:0] adr_i,
  input  logic [15:0]   dat_i,
  input  logic          we_i,
  output logic          done_o,
  output logic          fail_o,
  output logic [AW-1:0] qm_adr_o,
  output logic [15:0]   qm_dat_o,
  output logic          qm_we_o,
  output logic          qm_stb_o,
  input  logic          qm_ack_i,
  input  logic          qm_err_i
);
  logic          stb_q;
  logic [AW-1:0] adr_q;
  logic [15:0]   dat_q;
  logic          we_q;
  logic          tmo;
`ifdef BDLF_TIMEOUT_EN
  localparam int CW = $clog2(TMO_CYCLES + 1);
  logic [CW-1:0] cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else if (req_i) cnt_q <= '0;
    else if (stb_q) cnt_q <= cnt_q + 1'b1;
  end
  // Fires on the last held cycle so the strobe falls exactly TMO_CYCLES edges after rising.
  assign tmo = stb_q && (cnt_q == CW'(TMO_CYCLES - 1));
`else
  assign tmo = 1'b0;
`endif
  assign done_o   = stb_q & (qm_ack_i | qm_err_i | tmo);
  assign fail_o   = stb_q & (qm_err_i | tmo);
  assign qm_stb_o = stb_q;
  assign qm_adr_o = adr_q;
  assign qm_dat_o = dat_q;
  assign qm_we_o  = we_q;
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      stb_q <= 1'b0;
      adr_q <= '0;
      dat_q <= '0;
      we_q  <= 1'b0;
    end else if (req_i) begin
      stb_q <= 1'b1;
      adr_q <= adr_i;
      dat_q <= dat_i;
      we_q  <= we_i;
    end else if (done_o) begin
      stb_q <= 1'b0;
    end
  end
endmodule

// File: rtl/bdl_fetch.sv
// bdl_fetch: descriptor FETCH (host->BDL 1..3, flag write-back) and STATUS (BDL 4..5 -> host) sequencer.
// Optional host-ack timeout enabled by defining BDLF_TIMEOUT_EN.
module bdl_fetch #(
  parameter int          AW         = 21,
  parameter logic [15:0] FLAG_USE   = delqa_pkg::FLAG_USE,
  parameter int          TMO_CYCLES = 1023
) (
  input  logic          wb_clk_i,
  input  logic          wb_rst_n,
  input  logic          start_i,
  input  logic          cmd_i,
  input  logic [AW-1:0] base_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          err_o,
  output logic          valid_o,
  output logic          chain_o,
  output logic [AW-1:0] qm_adr_o,
  output logic [15:0]   qm_dat_o,
  input  logic [15:0]   qm_dat_i,
  output logic          qm_we_o,
  output logic          qm_stb_o,
  input  logic          qm_ack_i,
  input  logic          qm_err_i,
  output logic [2:0]    bdl_adr_o,
  output logic [15:0]   bdl_dat_o,
  input  logic [15:0]   bdl_dat_i,
  output logic          bdl_we_o,
  output logic          bdl_stb_o
);
  import delqa_pkg::*;
  state_e        state_q, state_d;
  logic [2:0]    k_q, k_d;
  logic [AW-1:0] base_q, base_d;
  logic [15:0]   dat_q, dat_d;
  logic          valid_q, valid_d, chain_q, chain_d, err_q, err_d;
  logic          req, req_we, q_done, q_fail;
  logic [AW-1:0] req_adr;
  logic [15:0]   req_dat;
  function automatic logic [AW-1:0] hadr(input logic [AW-1:0] b, input logic [2:0] k);
    return b + AW'(k);
  endfunction
  bdlf_qm_req #(.AW(AW), .TMO_CYCLES(TMO_CYCLES)) u_req (
    .clk_i    (wb_clk_i),
    .rst_n_i  (wb_rst_n),
    .req_i    (req),
    .adr_i    (req_adr),
    .dat_i    (req_dat),
    .we_i     (req_we),
    .done_o   (q_done),
    .fail_o   (q_fail),
    .qm_adr_o (qm_adr_o),
    .qm_dat_o (qm_dat_o),
    .qm_we_o  (qm_we_o),
    .qm_stb_o (qm_stb_o),
    .qm_ack_i (qm_ack_i),
    .qm_err_i (qm_err_i)
  );
  // Host requests are launched on the edge that enters HRD/FWR/SWR.
  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    base_d  = base_q;
    dat_d   = dat_q;
    valid_d = valid_q;
    chain_d = chain_q;
    err_d   = err_q;
    req     = 1'b0;
    req_we  = 1'b0;
    req_adr = '0;
    req_dat = '0;
    case (state_q)
      S_IDLE: if (start_i) begin
        base_d  = base_i;
        err_d   = 1'b0;
        k_d     = cmd_i ? BDL_ST1 : BDL_ADDR_HI;
        state_d = cmd_i ? S_SRD : S_HRD;
        req     = !cmd_i;
        req_adr = hadr(base_i, BDL_ADDR_HI);
      end
      S_HRD: if (q_done) begin
        err_d   = q_fail;
        dat_d   = qm_dat_i;
        state_d = q_fail ? S_DONE : S_BWR;
      end
      S_BWR: begin
        if (k_q == BDL_ADDR_HI) begin
          valid_d = dat_q[BIT_V];
          chain_d = dat_q[BIT_C];
        end
        if (k_q != BDL_LEN) begin
          k_d     = k_q + 3'd1;
          state_d = S_HRD;
          req     = 1'b1;
          req_adr = hadr(base_q, k_q + 3'd1);
        end else begin
          state_d = valid_q ? S_FWR : S_DONE;
          req     = valid_q;
          req_we  = 1'b1;
          req_adr = hadr(base_q, BDL_FLAG);
          req_dat = FLAG_USE;
        end
      end
      S_FWR: if (q_done) begin
        err_d   = q_fail;
        state_d = S_DONE;
      end
      S_SRD: state_d = S_SWT;
      S_SWT: begin
        dat_d   = bdl_dat_i;
        state_d = S_SWR;
        req     = 1'b1;
        req_we  = 1'b1;
        req_adr = hadr(base_q, k_q);
        req_dat = bdl_dat_i;
      end
      S_SWR: if (q_done) begin
        err_d   = q_fail;
        k_d     = k_q + 3'd1;
        state_d = (q_fail || k_q == BDL_ST2) ? S_DONE : S_SRD;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_n) begin
      state_q <= S_IDLE;
      k_q     <= '0;
      base_q  <= '0;
      dat_q   <= '0;
      valid_q <= 1'b0;
      chain_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      base_q  <= base_d;
      dat_q   <= dat_d;
      valid_q <= valid_d;
      chain_q <= chain_d;
      err_q   <= err_d;
    end
  end
  assign busy_o    = state_q != S_IDLE;
  assign done_o    = state_q == S_DONE;
  assign err_o     = err_q;
  assign valid_o   = valid_q;
  assign chain_o   = chain_q;
  assign bdl_stb_o = (state_q == S_BWR) || (state_q == S_SRD);
  assign bdl_we_o  = state_q == S_BWR;
  assign bdl_adr_o = bdl_stb_o ? k_q : 3'd0;
  assign bdl_dat_o = bdl_we_o ? dat_q : 16'h0;
endmodule

// File: tb/tb_bdl_fetch.sv
// tb_bdl_fetch: directed bench for bdl_fetch with a host-memory responder and a registered-read BDL model.
module tb_bdl_fetch;
  localparam int AW = 21;
  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, cmd = 1'b0;
  logic [AW-1:0] base = '0;
  logic          busy, done, err, valid, chain;
  logic [AW-1:0] qm_adr;
  logic [15:0]   qm_dat_o, qm_dat_i = 16'h0;
  logic          qm_we, qm_stb, qm_ack = 1'b0, qm_err = 1'b0;
  logic [2:0]    bdl_adr;
  logic [15:0]   bdl_dat_o, bdl_rd = 16'h0;
  logic          bdl_we, bdl_stb;
  logic [15:0]   hmem [int];
  logic [15:0]   bdl [8];
  int            checks = 0, failures = 0, n_done = 0, n_hwr = 0, n_rd = 0, err_n = 0;
  bit            ack_en = 1'b1;
  logic          e_after;
  always #5 clk = ~clk;
  bdl_fetch #(.AW(AW), .TMO_CYCLES(15)) dut (
    .wb_clk_i(clk), .wb_rst_n(rst_n), .start_i(start), .cmd_i(cmd), .base_i(base),
    .busy_o(busy), .done_o(done), .err_o(err), .valid_o(valid), .chain_o(chain),
    .qm_adr_o(qm_adr), .qm_dat_o(qm_dat_o), .qm_dat_i(qm_dat_i), .qm_we_o(qm_we),
    .qm_stb_o(qm_stb), .qm_ack_i(qm_ack), .qm_err_i(qm_err),
    .bdl_adr_o(bdl_adr), .bdl_dat_o(bdl_dat_o), .bdl_dat_i(bdl_rd),
    .bdl_we_o(bdl_we), .bdl_stb_o(bdl_stb)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  // Host responder: one cycle of ack (or injected err) per request, writes land on ack.
  always @(negedge clk) begin
    if (done) n_done++;
    if (qm_stb && !qm_ack && !qm_err) begin
      if (!qm_we && err_n != 0 && n_rd + 1 == err_n) begin
        qm_err = 1'b1;
        n_rd++;
      end else if (ack_en) begin
        qm_ack   = 1'b1;
        qm_dat_i = hmem.exists(int'(qm_adr)) ? hmem[int'(qm_adr)] : 16'h0;
        if (qm_we) begin
          hmem[int'(qm_adr)] = qm_dat_o;
          n_hwr++;
        end else n_rd++;
      end
    end else begin
      qm_ack = 1'b0;
      qm_err = 1'b0;
    end
  end
  always @(posedge clk) begin
    if (bdl_stb && bdl_we) bdl[bdl_adr] = bdl_dat_o;
    if (bdl_stb && !bdl_we) bdl_rd <= bdl[bdl_adr];
  end
  task automatic run(input logic c, input logic [AW-1:0] b, output logic e1);
    int n0;
    n0 = n_done;
    @(negedge clk);
    start = 1'b1;
    cmd   = c;
    base  = b;
    @(negedge clk);
    start = 1'b0;
    e1    = err;
    check("busy_after_start", busy, 1);
    for (int i = 0; i < 300 && n_done == n0; i++) @(negedge clk);
    repeat (3) @(negedge clk);
    check("done_pulses", n_done - n0, 1);
    check("idle_after_done", busy, 0);
  endtask
  initial begin
    for (int i = 0; i < 8; i++) bdl[i] = 16'h0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_qm_stb", qm_stb, 0);
    check("rst_bdl_stb", bdl_stb, 0);
    check("rst_qm_adr", qm_adr, 0);
    rst_n = 1'b1;
    // FETCH with V=1
    hmem[32'h1001] = 16'h8012; hmem[32'h1002] = 16'h3456; hmem[32'h1003] = 16'hFA00;
    n_hwr = 0;
    run(1'b0, 21'h001000, e_after);
    check("f1_bdl1", bdl[1], 16'h8012);
    check("f1_bdl2", bdl[2], 16'h3456);
    check("f1_bdl3", bdl[3], 16'hFA00);
    check("f1_flag", hmem[32'h1000], 16'hC000);
    check("f1_hwr", n_hwr, 1);
    check("f1_valid", valid, 1);
    check("f1_chain", chain, 0);
    check("f1_err", err, 0);
    // FETCH with V=0, C=1: no flag write
    hmem[32'h2001] = 16'h4000; hmem[32'h2002] = 16'h1111; hmem[32'h2003] = 16'h2222;
    n_hwr = 0;
    run(1'b0, 21'h002000, e_after);
    check("f2_bdl1", bdl[1], 16'h4000);
    check("f2_bdl2", bdl[2], 16'h1111);
    check("f2_bdl3", bdl[3], 16'h2222);
    check("f2_hwr", n_hwr, 0);
    check("f2_noflag", hmem.exists(32'h2000), 0);
    check("f2_valid", valid, 0);
    check("f2_chain", chain, 1);
    // STATUS with address wrap
    bdl[4] = 16'h200C; bdl[5] = 16'h0505;
    n_hwr = 0;
    run(1'b1, 21'h1FFFFB, e_after);
    check("s_top", hmem[32'h1FFFFF], 16'h200C);
    check("s_wrap", hmem[32'h0], 16'h0505);
    check("s_hwr", n_hwr, 2);
    check("s_err", err, 0);
    // Error on second read
    bdl[2] = 16'hAAAA; bdl[3] = 16'hBBBB;
    hmem[32'h3001] = 16'h8000; hmem[32'h3002] = 16'h1234; hmem[32'h3003] = 16'h5678;
    n_hwr = 0; n_rd = 0; err_n = 2;
    run(1'b0, 21'h003000, e_after);
    err_n = 0;
    check("e_err", err, 1);
    check("e_bdl1", bdl[1], 16'h8000);
    check("e_bdl2", bdl[2], 16'hAAAA);
    check("e_bdl3", bdl[3], 16'hBBBB);
    check("e_hwr", n_hwr, 0);
    check("e_noflag", hmem.exists(32'h3000), 0);
    run(1'b0, 21'h001000, e_after);
    check("e_clear", e_after, 0);
    check("e_clear_end", err, 0);
    // Start while busy, then reset mid-HRD
    ack_en = 1'b0;
    @(negedge clk);
    start = 1'b1; cmd = 1'b0; base = 21'h004000;
    @(negedge clk);
    cmd = 1'b1; base = 21'h005000;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    check("r_busy", busy, 1);
    check("r_stb", qm_stb, 1);
    check("r_adr", qm_adr, 21'h004001);
    check("r_we", qm_we, 0);
    check("r_no_bdl", bdl_stb, 0);
    begin
      int n0;
      n0 = n_done;
      rst_n = 1'b0;
      @(negedge clk);
      check("r_busy0", busy, 0);
      check("r_err0", err, 0);
      check("r_valid0", valid, 0);
      check("r_chain0", chain, 0);
      check("r_stb0", qm_stb, 0);
      check("r_adr0", qm_adr, 0);
      check("r_dat0", qm_dat_o, 0);
      check("r_bdl0", {bdl_stb, bdl_we, bdl_adr, bdl_dat_o}, 0);
      rst_n  = 1'b1;
      ack_en = 1'b1;
      repeat (10) @(negedge clk);
      check("r_no_done", n_done - n0, 0);
      check("r_idle", busy, 0);
    end
`ifdef BDLF_TIMEOUT_EN
    begin
      int held;
      ack_en = 1'b0;
      held   = 0;
      @(negedge clk);
      start = 1'b1; cmd = 1'b0; base = 21'h006000;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 100 && qm_stb; i++) begin
        held++;
        @(negedge clk);
      end
      check("t_held", held, 15);
      check("t_err", err, 1);
      for (int i = 0; i < 5 && !done; i++) @(negedge clk);
      check("t_done", done, 1);
      ack_en = 1'b1;
      repeat (3) @(negedge clk);
    end
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
